// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encodings for the execute stage.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry, overflow and illegal-code detect.
// Shift codes 010/011 are supported only when ALU_SHIFT_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       code_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_o,
    output logic             v_o,
    output logic             illegal_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

`ifdef ALU_SHIFT_EN
    // A guard bit on each side of A catches the last bit shifted out.
    logic [3:0]     amt;
    logic [WIDTH:0] sll_ext;
    logic [WIDTH:0] srl_ext;

    assign amt     = b_i[3:0];
    assign sll_ext = {1'b0, a_i} << amt;
    assign srl_ext = {a_i, 1'b0} >> amt;
`endif

    always_comb begin
        result_o  = '0;
        c_o       = 1'b0;
        v_o       = 1'b0;
        illegal_o = 1'b0;
        case (code_i)
            ALU_ADD: begin
                result_o = sum[WIDTH-1:0];
                c_o      = sum[WIDTH];
                v_o      = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o = diff[WIDTH-1:0];
                c_o      = diff[WIDTH];
                v_o      = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOT: result_o = ~a_i;
            ALU_XOR: result_o = a_i ^ b_i;
`ifdef ALU_SHIFT_EN
            ALU_SLL: begin
                result_o = sll_ext[WIDTH-1:0];
                c_o      = sll_ext[WIDTH];
            end
            ALU_SRL: begin
                result_o = srl_ext[WIDTH:1];
                c_o      = srl_ext[0];
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Registered ALU execute stage with valid/ready handshake and one-entry output buffer.
// Optional shift ops enabled by ALU_SHIFT_EN (see alu_core).
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_Code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             z_q, n_q, c_q, v_q, ill_q;

    logic [WIDTH-1:0] result_next;
    logic             c_next, v_next, illegal_next;
    logic             load;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .code_i    (ALU_Code),
        .a_i       (op_a),
        .b_i       (op_b),
        .result_o  (result_next),
        .c_o       (c_next),
        .v_o       (v_next),
        .illegal_o (illegal_next)
    );

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign load      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Z is captured at load time so the reset value can be 0 while result is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
        end else if (load) begin
            result_q <= result_next;
            z_q      <= (result_next == '0);
            n_q      <= result_next[WIDTH-1];
            c_q      <= c_next;
            v_q      <= v_next;
            ill_q    <= illegal_next;
        end
    end

    assign result  = result_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;
    assign flag_c  = c_q;
    assign flag_v  = v_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors, monitor pops on each output transfer.
module tb_alu_exec;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALU_Code;
    logic [W-1:0] op_a, op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v, illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z, n, c, v, il;
    } exp_t;

    exp_t sb[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_Code(ALU_Code), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            exp_t act;
            act = '{result, flag_z, flag_n, flag_c, flag_v, illegal};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got r=%h zncvi=%b%b%b%b%b, expected none",
                         result, flag_z, flag_n, flag_c, flag_v, illegal);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL result_flags: got r=%h zncvi=%b%b%b%b%b, expected r=%h zncvi=%b%b%b%b%b",
                             result, flag_z, flag_n, flag_c, flag_v, illegal,
                             e.r, e.z, e.n, e.c, e.v, e.il);
                end
            end
        end
    end

    task automatic send(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic z, input logic n,
                        input logic c, input logic v, input logic il);
        int t;
        in_valid = 1'b1;
        ALU_Code = code;
        op_a     = a;
        op_b     = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
        end else begin
            sb.push_back('{r, z, n, c, v, il});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALU_Code = '0; op_a = '0; op_b = '0;
        idle(2);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result",    {16'b0, result}, 32'd0);
        chk("reset_flags",     {27'b0, flag_z, flag_n, flag_c, flag_v, illegal}, 32'd0);
        rst = 1'b0;
        idle(1);

        send(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 0);
        chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
        send(3'b001, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0, 0);
        send(3'b001, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 0, 0);
`ifdef ALU_SHIFT_EN
        send(3'b010, 16'h8001, 16'h0001, 16'h0002, 0, 0, 1, 0, 0);
`else
        send(3'b010, 16'h8001, 16'h0001, 16'h0000, 1, 0, 0, 0, 1);
`endif
        idle(2);

        // Back-pressure: XOR result must hold while downstream stalls.
        out_ready = 1'b0;
        send(3'b111, 16'hFF00, 16'h0FF0, 16'hF0F0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result",    {16'b0, result}, 32'h0000F0F0);
            chk("bp_in_ready",  {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b100, 16'hFF00, 16'h0FF0, 16'h0F00, 0, 0, 0, 0, 0);
        chk("no_bubble_valid",  {31'b0, out_valid}, 32'd1);
        chk("no_bubble_result", {16'b0, result}, 32'h00000F00);

        // Streaming: one result per cycle.
        send(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b000, 16'h8000, 16'h8000, 16'h0000, 1, 0, 1, 1, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b101, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 0, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b110, 16'h1234, 16'hAAAA, 16'hEDCB, 0, 1, 0, 0, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b100, 16'hF0F0, 16'hFFFF, 16'hF0F0, 0, 1, 0, 0, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        send(3'b001, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 1, 0, 0);
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
`ifdef ALU_SHIFT_EN
        send(3'b011, 16'h8009, 16'h0004, 16'h0800, 0, 0, 1, 0, 0);
`else
        send(3'b011, 16'h8009, 16'h0004, 16'h0000, 1, 0, 0, 0, 1);
`endif
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        idle(2);

        // Reset while a stalled result is pending; the reset-cycle input is dropped.
        out_ready = 1'b0;
        send(3'b000, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0, 0);
        rst = 1'b1; in_valid = 1'b1;
        ALU_Code = 3'b000; op_a = 16'h0005; op_b = 16'h0005;
        idle(1);
        sb.delete();
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_result",    {16'b0, result}, 32'd0);
        chk("rst_mid_flags",     {27'b0, flag_z, flag_n, flag_c, flag_v, illegal}, 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(1);
        chk("rst_input_dropped", {31'b0, out_valid}, 32'd0);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
